// File: rtl/ft_pkg.sv
// Shared opcodes, response tags and FSM encodings for the FT245 command
// controller and its TX scheduler.
package ft_pkg;

  localparam logic [7:0] OP_WR    = 8'h01;
  localparam logic [7:0] OP_RD    = 8'h02;
  localparam logic [7:0] OP_START = 8'h03;
  localparam logic [7:0] OP_ABORT = 8'h04;

  localparam logic [7:0] RSP_WR    = 8'h81;
  localparam logic [7:0] RSP_RD    = 8'h82;
  localparam logic [7:0] RSP_START = 8'h83;
  localparam logic [7:0] RSP_ABORT = 8'h84;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [2:0] {
    P_OP,
    P_ADDR,
    P_DATA,
    P_EXEC,
    P_RD
  } parse_state_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_RSP0,
    T_RSP1,
    T_PIX0,
    T_PIX1
  } tx_state_t;

  function automatic logic [7:0] rsp_tag(input logic [7:0] op);
    case (op)
      OP_WR:    rsp_tag = RSP_WR;
      OP_RD:    rsp_tag = RSP_RD;
      OP_START: rsp_tag = RSP_START;
      OP_ABORT: rsp_tag = RSP_ABORT;
      default:  rsp_tag = RSP_ERR;
    endcase
  endfunction

endpackage

// File: rtl/ft_cmd_ctrl_if.sv
// FT245 FIFO port bundle: RX read side and TX write side on the system clock.
interface ft_cmd_ctrl_if;
  logic [7:0] rx_rdata;
  logic       rx_rempty;
  logic       rx_rinc;
  logic [7:0] tx_wdata;
  logic       tx_wfull;
  logic       tx_winc;

  modport master (
    input  rx_rdata, rx_rempty, tx_wfull,
    output rx_rinc, tx_wdata, tx_winc
  );

  modport slave (
    output rx_rdata, rx_rempty, tx_wfull,
    input  rx_rinc, tx_wdata, tx_winc
  );
endinterface

// File: rtl/ft_tx_sched.sv
// TX FIFO write-port scheduler: sends 2-byte responses and 16-bit pixels,
// never splitting a pair, with responses winning only at idle.
module ft_tx_sched
  import ft_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rsp_set,
  input  logic [7:0]  rsp_b0,
  input  logic [7:0]  rsp_b1,
  output logic        rsp_pend,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        tx_wfull,
  output logic        tx_winc,
  output logic [7:0]  tx_wdata
);

  tx_state_t   state_q, state_d;
  logic        rsp_pend_q, rsp_pend_d;
  logic [7:0]  rsp0_q, rsp0_d;
  logic [7:0]  rsp1_q, rsp1_d;
  logic [15:0] pix_q, pix_d;

  assign rsp_pend = rsp_pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= T_IDLE;
      rsp_pend_q <= 1'b0;
      rsp0_q     <= '0;
      rsp1_q     <= '0;
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      rsp_pend_q <= rsp_pend_d;
      rsp0_q     <= rsp0_d;
      rsp1_q     <= rsp1_d;
      pix_q      <= pix_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rsp_pend_d = rsp_pend_q;
    rsp0_d     = rsp0_q;
    rsp1_d     = rsp1_q;
    pix_d      = pix_q;
    pix_ready  = 1'b0;
    tx_winc    = 1'b0;
    tx_wdata   = '0;

    case (state_q)
      T_IDLE: begin
        if (rsp_pend_q) begin
          state_d = T_RSP0;
        end else if (pix_valid) begin
          pix_ready = 1'b1;
          pix_d     = pix_data;
          state_d   = T_PIX0;
        end
      end
      T_RSP0: begin
        tx_wdata = rsp0_q;
        tx_winc  = !tx_wfull;
        if (tx_winc) state_d = T_RSP1;
      end
      T_RSP1: begin
        tx_wdata = rsp1_q;
        tx_winc  = !tx_wfull;
        if (tx_winc) begin
          rsp_pend_d = 1'b0;
          state_d    = T_IDLE;
        end
      end
      T_PIX0: begin
        tx_wdata = pix_q[15:8];
        tx_winc  = !tx_wfull;
        if (tx_winc) state_d = T_PIX1;
      end
      T_PIX1: begin
        tx_wdata = pix_q[7:0];
        tx_winc  = !tx_wfull;
        if (tx_winc) state_d = T_IDLE;
      end
      default: state_d = T_IDLE;
    endcase

    // A new response is loaded last so it can never be lost to a clear.
    if (rsp_set) begin
      rsp_pend_d = 1'b1;
      rsp0_d     = rsp_b0;
      rsp1_d     = rsp_b1;
    end
  end

endmodule

// File: rtl/ft_cmd_ctrl.sv
// Host command parser for the FT245 link: decodes 3-byte frames into register
// bus cycles and readout pulses, and hands responses to the TX scheduler.
module ft_cmd_ctrl
  import ft_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 65536
) (
  input  logic              clk,
  input  logic              rst,
  ft_cmd_ctrl_if.master     fifo,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              readout_start,
  output logic              readout_abort,
  input  logic [15:0]       pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [7:0]        drop_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  parse_state_t      state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [7:0]        drop_q, drop_d;
  logic              parsing;
  logic              rsp_pend;
  logic              rsp_set;
  logic [7:0]        rsp_b0, rsp_b1;

  assign reg_addr  = addr_q;
  assign reg_wdata = data_q;
  assign drop_cnt  = drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= P_OP;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      timer_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    timer_d       = '0;
    drop_d        = drop_q;
    reg_we        = 1'b0;
    reg_re        = 1'b0;
    readout_start = 1'b0;
    readout_abort = 1'b0;
    rsp_set       = 1'b0;
    rsp_b0        = '0;
    rsp_b1        = '0;

    parsing      = (state_q == P_OP) || (state_q == P_ADDR) || (state_q == P_DATA);
    fifo.rx_rinc = parsing && !fifo.rx_rempty && !rsp_pend;

    case (state_q)
      P_OP: begin
        if (fifo.rx_rinc) begin
          op_d    = fifo.rx_rdata;
          state_d = P_ADDR;
        end
      end
      P_ADDR, P_DATA: begin
        if (fifo.rx_rinc) begin
          if (state_q == P_ADDR) begin
            addr_d  = fifo.rx_rdata[ADDR_W-1:0];
            state_d = P_DATA;
          end else begin
            data_d  = fifo.rx_rdata;
            state_d = P_EXEC;
          end
        end else if (timer_q == TIMER_LAST) begin
          // Host stalled mid-frame: drop what we have and resync on the next byte.
          state_d = P_OP;
          op_d    = '0;
          addr_d  = '0;
          data_d  = '0;
          drop_d  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        end else if (fifo.rx_rempty) begin
          timer_d = timer_q + 1'b1;
        end else begin
          timer_d = timer_q;
        end
      end
      P_EXEC: begin
        state_d = P_OP;
        rsp_b0  = rsp_tag(op_q);
        case (op_q)
          OP_WR: begin
            reg_we  = 1'b1;
            rsp_set = 1'b1;
            rsp_b1  = 8'(addr_q);
          end
          OP_RD: begin
            reg_re  = 1'b1;
            state_d = P_RD;
          end
          OP_START: begin
            readout_start = 1'b1;
            rsp_set       = 1'b1;
          end
          OP_ABORT: begin
            readout_abort = 1'b1;
            rsp_set       = 1'b1;
          end
          default: begin
            rsp_set = 1'b1;
            rsp_b1  = op_q;
          end
        endcase
      end
      P_RD: begin
        rsp_set = 1'b1;
        rsp_b0  = RSP_RD;
        rsp_b1  = reg_rdata;
        state_d = P_OP;
      end
      default: state_d = P_OP;
    endcase
  end

  ft_tx_sched u_tx_sched (
    .clk       (clk),
    .rst       (rst),
    .rsp_set   (rsp_set),
    .rsp_b0    (rsp_b0),
    .rsp_b1    (rsp_b1),
    .rsp_pend  (rsp_pend),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .tx_wfull  (fifo.tx_wfull),
    .tx_winc   (fifo.tx_winc),
    .tx_wdata  (fifo.tx_wdata)
  );

endmodule

// File: tb/tb_ft_cmd_ctrl.sv
// Self-checking bench for ft_cmd_ctrl: directed frames, stream arbitration,
// back-pressure, timeout/saturation and a randomized command/pixel mix.
module tb_ft_cmd_ctrl;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  regAddr, regWdata, regRdata, dropCnt;
   logic        regWe, regRe, readoutStart, readoutAbort, pixReady, pixValid;
   logic [15:0] pixData;

   ft_cmd_ctrl_if fifoIf ();

   ft_cmd_ctrl #(.ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo          (fifoIf),
      .reg_addr      (regAddr),
      .reg_wdata     (regWdata),
      .reg_we        (regWe),
      .reg_re        (regRe),
      .reg_rdata     (regRdata),
      .readout_start (readoutStart),
      .readout_abort (readoutAbort),
      .pix_data      (pixData),
      .pix_valid     (pixValid),
      .pix_ready     (pixReady),
      .drop_cnt      (dropCnt)
   );

   // Free-running 100 MHz system clock shared by the FIFO models.
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lastPopCyc = 0;
   int reCnt = 0, startCnt = 0, abortCnt = 0;
   int dropExp = 0;
   int holdCnt = 0, holdSeen = 0;
   bit holdArm = 0, holdNow = 0;
   bit pixEn = 0;
   int fullPct = 0;
   logic [7:0] holdExp = 8'h00;

   logic [7:0]  rxQ[$];
   logic [7:0]  txLog[$];
   logic [7:0]  rdValQ[$];
   logic [15:0] pixQ[$];
   logic [15:0] weLog[$];
   int          weLat[$];

   bit         smpRinc = 0, smpWinc = 0, smpHs = 0, smpRe = 0;
   logic [7:0] smpWdata = 8'h00;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Spec-level reference: the 2-byte response a frame must produce.
   function automatic logic [15:0] refResponse(input logic [7:0] op, input logic [7:0] a,
                                               input logic [7:0] rdv);
      case (op)
         8'h01:   return {8'h81, a};
         8'h02:   return {8'h82, rdv};
         8'h03:   return {8'h83, 8'h00};
         8'h04:   return {8'h84, 8'h00};
         default: return {8'hEE, op};
      endcase
   endfunction

   // Cycle engine: at each falling edge it applies what the DUT did at the
   // rising edge just passed (pops, writes, pixel accepts), drives the FIFO,
   // register and pixel models for the next edge, then samples the DUT's
   // combinational outputs 1 time unit later and logs strobes.
   always begin
      @(negedge clk);
      cyc++;
      if (smpRinc && rxQ.size() > 0) void'(rxQ.pop_front());
      if (smpWinc) txLog.push_back(smpWdata);
      if (smpHs && pixQ.size() > 0) void'(pixQ.pop_front());
      if (smpRe && rdValQ.size() > 0) regRdata = rdValQ.pop_front();
      else regRdata = 8'($urandom);
      if (holdArm && smpWinc) begin
         holdArm = 0;
         holdCnt = 10;
      end

      fifoIf.rx_rempty = (rxQ.size() == 0);
      fifoIf.rx_rdata  = (rxQ.size() != 0) ? rxQ[0] : 8'($urandom);
      holdNow = (holdCnt > 0);
      if (holdNow) begin
         fifoIf.tx_wfull = 1'b1;
         holdCnt--;
      end else begin
         fifoIf.tx_wfull = ($urandom_range(0, 99) < fullPct);
      end
      pixValid = pixEn && (pixQ.size() != 0);
      pixData  = pixValid ? pixQ[0] : 16'($urandom);

      #1;
      smpRinc  = fifoIf.rx_rinc;
      smpWinc  = fifoIf.tx_winc;
      smpWdata = fifoIf.tx_wdata;
      smpHs    = pixValid && pixReady;
      smpRe    = regRe;
      if (fifoIf.rx_rempty) checkOutput("rinc_when_empty", fifoIf.rx_rinc, 0);
      if (fifoIf.tx_wfull) checkOutput("winc_when_full", fifoIf.tx_winc, 0);
      if (holdNow) begin
         holdSeen++;
         checkOutput("hold_wdata", fifoIf.tx_wdata, holdExp);
      end
      if (smpRinc) lastPopCyc = cyc;
      if (regWe) begin
         weLog.push_back({regAddr, regWdata});
         weLat.push_back(cyc - lastPopCyc);
      end
      if (regRe) reCnt++;
      if (readoutStart) startCnt++;
      if (readoutAbort) abortCnt++;
   end

   // Main-thread timing: act just after a rising edge, clear of the engine.
   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d);
      rxQ.push_back(op);
      rxQ.push_back(a);
      rxQ.push_back(d);
   endtask

   task automatic clearLogs();
      txLog.delete();
      weLog.delete();
      weLat.delete();
      reCnt = 0;
      startCnt = 0;
      abortCnt = 0;
   endtask

   task automatic waitTx(input int n, input int budget, input string tag);
      int k = 0;
      while (txLog.size() < n && k < budget) begin
         waitCycles(1);
         k++;
      end
      if (txLog.size() < n) checkOutput(tag, txLog.size(), n);
   endtask

   task automatic checkTx(input string tag, input logic [7:0] expSeq[$]);
      checkOutput({tag, "_len"}, txLog.size(), expSeq.size());
      for (int i = 0; i < expSeq.size() && i < txLog.size(); i++)
         checkOutput(tag, txLog[i], expSeq[i]);
   endtask

   task automatic checkReset();
      checkOutput("rst_rinc", fifoIf.rx_rinc, 0);
      checkOutput("rst_winc", fifoIf.tx_winc, 0);
      checkOutput("rst_wdata", fifoIf.tx_wdata, 0);
      checkOutput("rst_addr", regAddr, 0);
      checkOutput("rst_wdata_reg", regWdata, 0);
      checkOutput("rst_we", regWe, 0);
      checkOutput("rst_re", regRe, 0);
      checkOutput("rst_start", readoutStart, 0);
      checkOutput("rst_abort", readoutAbort, 0);
      checkOutput("rst_pix_ready", pixReady, 0);
      checkOutput("rst_drop", dropCnt, 0);
   endtask

   // Guard against a hung DUT or bench.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenarios followed by a randomized command/pixel mix.
   initial begin
      logic [15:0] expRsp[$], expPix[$], expWr[$];
      int expRe, expStart, expAbort, ri, pi;

      rst = 1'b1;
      fifoIf.rx_rempty = 1'b1;
      fifoIf.rx_rdata  = 8'h00;
      fifoIf.tx_wfull  = 1'b0;
      regRdata = 8'h00;
      pixValid = 1'b0;
      pixData  = 16'h0000;
      waitCycles(3);
      checkReset();
      rst = 1'b0;
      waitCycles(2);

      // Register write.
      clearLogs();
      applyStimulus(8'h01, 8'h05, 8'hA5);
      waitTx(2, 50, "wr_timeout");
      waitCycles(4);
      checkTx("wr_rsp", '{8'h81, 8'h05});
      checkOutput("wr_we_count", weLog.size(), 1);
      if (weLog.size() > 0) begin
         checkOutput("wr_addr_data", weLog[0], 16'h05A5);
         checkOutput("wr_we_latency", weLat[0], 1);
      end

      // Register read.
      clearLogs();
      rdValQ.push_back(8'h3C);
      applyStimulus(8'h02, 8'h07, 8'h99);
      waitTx(2, 50, "rd_timeout");
      waitCycles(4);
      checkTx("rd_rsp", '{8'h82, 8'h3C});
      checkOutput("rd_no_we", weLog.size(), 0);
      checkOutput("rd_re_count", reCnt, 1);

      // Unknown opcode, then start and abort.
      clearLogs();
      applyStimulus(8'h7F, 8'h00, 8'h00);
      waitTx(2, 50, "err_timeout");
      waitCycles(4);
      checkTx("err_rsp", '{8'hEE, 8'h7F});
      checkOutput("err_strobes", weLog.size() + reCnt + startCnt + abortCnt, 0);
      clearLogs();
      applyStimulus(8'h03, 8'h00, 8'h00);
      applyStimulus(8'h04, 8'h00, 8'h00);
      waitTx(4, 80, "ctl_timeout");
      waitCycles(4);
      checkTx("ctl_rsp", '{8'h83, 8'h00, 8'h84, 8'h00});
      checkOutput("start_count", startCnt, 1);
      checkOutput("abort_count", abortCnt, 1);

      // Write command arriving while a pixel pair is in flight.
      clearLogs();
      applyStimulus(8'h01, 8'h11, 8'h22);
      waitCycles(2);
      pixQ.push_back(16'h1234);
      pixQ.push_back(16'hABCD);
      pixEn = 1;
      waitTx(6, 80, "mix_timeout");
      waitCycles(4);
      checkTx("mix_seq", '{8'h12, 8'h34, 8'h81, 8'h11, 8'hAB, 8'hCD});

      // Back-pressure held during the second pixel byte.
      clearLogs();
      holdSeen = 0;
      holdExp = 8'h66;
      holdArm = 1;
      pixQ.push_back(16'h5566);
      waitTx(2, 80, "hold_timeout");
      waitCycles(5);
      checkTx("hold_seq", '{8'h55, 8'h66});
      checkOutput("hold_cycles", holdSeen, 10);

      // Partial frame times out; the following frame must parse cleanly.
      clearLogs();
      rxQ.push_back(8'h01);
      rxQ.push_back(8'h05);
      waitCycles(8);
      checkOutput("drop_early", dropCnt, dropExp);
      waitCycles(TIMEOUT + 4);
      dropExp++;
      checkOutput("drop_after_timeout", dropCnt, dropExp);
      checkOutput("drop_no_rsp", txLog.size(), 0);
      rdValQ.push_back(8'h9A);
      applyStimulus(8'h02, 8'h05, 8'h00);
      waitTx(2, 50, "post_drop_timeout");
      waitCycles(4);
      checkTx("post_drop_rsp", '{8'h82, 8'h9A});
      checkOutput("post_drop_no_we", weLog.size(), 0);

      // Drive the drop counter into saturation.
      clearLogs();
      for (int i = 0; i < 255; i++) begin
         rxQ.push_back(8'h01);
         waitCycles(TIMEOUT + 6);
         dropExp = (dropExp < 255) ? dropExp + 1 : 255;
         if (i == 253 || i == 254) checkOutput("drop_saturate", dropCnt, dropExp);
      end
      checkOutput("sat_no_rsp", txLog.size(), 0);

      // Reset in the middle of a frame.
      clearLogs();
      rxQ.push_back(8'h01);
      rxQ.push_back(8'h06);
      waitCycles(4);
      rst = 1'b1;
      waitCycles(2);
      checkReset();
      dropExp = 0;
      rst = 1'b0;
      waitCycles(2);
      applyStimulus(8'h01, 8'h07, 8'h5A);
      waitTx(2, 50, "post_rst_timeout");
      waitCycles(4);
      checkTx("post_rst_rsp", '{8'h81, 8'h07});
      checkOutput("post_rst_we_count", weLog.size(), 1);
      if (weLog.size() > 0) checkOutput("post_rst_we", weLog[0], 16'h075A);

      // Randomized commands interleaved with a pixel stream under back-pressure.
      clearLogs();
      fullPct = 25;
      expRe = 0;
      expStart = 0;
      expAbort = 0;
      for (int i = 0; i < 40; i++) begin
         logic [7:0] op, a, d, rdv;
         logic [15:0] w;
         case ($urandom_range(0, 5))
            0: op = 8'h01;
            1: op = 8'h02;
            2: op = 8'h03;
            3: op = 8'h04;
            default: op = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(5, 255));
         endcase
         a = 8'($urandom);
         d = 8'($urandom);
         rdv = 8'($urandom);
         if (op == 8'h01) expWr.push_back({a, d});
         if (op == 8'h02) begin
            rdValQ.push_back(rdv);
            expRe++;
         end
         if (op == 8'h03) expStart++;
         if (op == 8'h04) expAbort++;
         expRsp.push_back(refResponse(op, a, rdv));
         rxQ.push_back(op);
         waitCycles($urandom_range(0, 3));
         rxQ.push_back(a);
         waitCycles($urandom_range(0, 3));
         rxQ.push_back(d);
         if ($urandom_range(0, 1) == 1) begin
            w = {1'b0, 15'($urandom)};
            pixQ.push_back(w);
            expPix.push_back(w);
         end
         waitCycles($urandom_range(0, 3));
      end
      waitTx(2 * (expRsp.size() + expPix.size()), 20000, "rnd_drain");
      waitCycles(20);

      ri = 0;
      pi = 0;
      for (int k = 0; k + 1 < txLog.size(); k += 2) begin
         logic [15:0] pair;
         pair = {txLog[k], txLog[k + 1]};
         if (pair[15]) begin
            if (ri < expRsp.size()) checkOutput("rnd_rsp", pair, expRsp[ri]);
            ri++;
         end else begin
            if (pi < expPix.size()) checkOutput("rnd_pix", pair, expPix[pi]);
            pi++;
         end
      end
      checkOutput("rnd_tx_len", txLog.size(), 2 * (expRsp.size() + expPix.size()));
      checkOutput("rnd_rsp_count", ri, expRsp.size());
      checkOutput("rnd_pix_count", pi, expPix.size());
      checkOutput("rnd_we_count", weLog.size(), expWr.size());
      for (int k = 0; k < weLog.size() && k < expWr.size(); k++)
         checkOutput("rnd_we", weLog[k], expWr[k]);
      checkOutput("rnd_re_count", reCnt, expRe);
      checkOutput("rnd_start_count", startCnt, expStart);
      checkOutput("rnd_abort_count", abortCnt, expAbort);
      checkOutput("rnd_drop", dropCnt, dropExp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ft_cmd_ctrl.md
Name: ft_cmd_ctrl

Overview:
- Host-side command and stream controller between the FT245 RX/TX FIFOs (system-clock side) and the camera logic.
- Parses 3-byte host command frames from the RX FIFO and drives a byte-wide register bus and readout control pulses.
- Arbitrates the single TX FIFO write port between command responses and the 16-bit CCD pixel stream.

Parameters:
- ADDR_W, 8, register address width; low ADDR_W bits of the address byte are used.
- TIMEOUT, 65536, cycles allowed between bytes of one frame before the partial frame is dropped; counter width $clog2(TIMEOUT).

Ports:
- clk  in  1  system clock, shared with the FIFO ports
- rst  in  1  asynchronous active-high reset
- rx_rdata  in  8  RX FIFO head byte; first-word fall-through, valid while rx_rempty=0
- rx_rempty  in  1  RX FIFO empty
- rx_rinc  out  1  pop RX FIFO head this cycle
- tx_wdata  out  8  byte to TX FIFO
- tx_wfull  in  1  TX FIFO full
- tx_winc  out  1  write tx_wdata this cycle
- reg_addr  out  ADDR_W  register address
- reg_wdata  out  8  register write data
- reg_we  out  1  register write strobe, 1 cycle
- reg_re  out  1  register read strobe, 1 cycle
- reg_rdata  in  8  read data, valid the cycle after reg_re
- readout_start  out  1  1-cycle pulse
- readout_abort  out  1  1-cycle pulse
- pix_data  in  16  pixel word
- pix_valid  in  1  pixel available
- pix_ready  out  1  pixel accepted when pix_valid&pix_ready
- drop_cnt  out  8  saturating count of timed-out frames

Behaviour:
- Reset: every output is 0; parser is in P_OP; TX FSM is in T_IDLE; rsp_pend=0; drop_cnt=0. Reset mid-frame or mid-pixel discards the partial frame or pixel.
- Pop rule: rx_rinc = (parser in P_OP, P_ADDR or P_DATA) & !rx_rempty & !rsp_pend. It is combinational; the byte is latched in the same cycle.
- Parser FSM:
  - P_OP: pop the byte into op, go to P_ADDR.
  - P_ADDR: pop the byte into addr, go to P_DATA.
  - P_DATA: pop the byte into data, go to P_EXEC.
  - P_EXEC (1 cycle), by opcode:
    - 0x01 write: reg_we=1 with addr/data; response {0x81, addr}.
    - 0x02 read: reg_re=1; go to P_RD. P_RD captures reg_rdata; response {0x82, reg_rdata}.
    - 0x03: readout_start=1; response {0x83, 0x00}.
    - 0x04: readout_abort=1; response {0x84, 0x00}.
    - Other opcodes: no strobe; response {0xEE, op}.
  - After P_EXEC or P_RD, set rsp_pend and return to P_OP.
- Parser stall: while rsp_pend=1 the parser pops nothing.
- Timeout: in P_ADDR and P_DATA, the timer counts each cycle rx_rempty=1 and clears on every pop. When it reaches TIMEOUT-1, the parser returns to P_OP, discards partial bytes, and increments drop_cnt (saturates at 255). No response is sent.
- Latency: reg_we is asserted 1 cycle after the cycle the data byte is popped. The first response byte can be written 1 cycle after rsp_pend sets.
- TX FSM:
  - T_IDLE: if rsp_pend, go to T_RSP0. Else if pix_valid, assert pix_ready (combinational, T_IDLE & !rsp_pend). On handshake, latch pix_data and go to T_PIX0.
  - T_RSP0: write byte 0, then go to T_RSP1. T_RSP1: write byte 1, clear rsp_pend, go to T_IDLE.
  - T_PIX0: write pix[15:8], then go to T_PIX1. T_PIX1: write pix[7:0], go to T_IDLE.
  - In each write state, tx_winc = !tx_wfull. The FSM advances only when tx_winc=1; otherwise it holds with data stable.
  - tx_wdata is a combinational mux of the latched bytes selected by state.
- Priority and atomicity:
  - Responses have priority only at T_IDLE. A pixel pair is never split, and response bytes are never interleaved with pixel bytes.
  - A response pending and pix_valid in the same T_IDLE cycle: the response wins and pix_ready=0.
- Never write when full: tx_winc=0 whenever tx_wfull=1. rx_rinc=0 whenever rx_rempty=1.
- Throughput: at most one response or pixel per 3 cycles (idle plus 2 bytes). Pixel streaming at full rate is not required.

Decomposition:
- Shared package ft_pkg:
  - opcode constants OP_WR, OP_RD, OP_START, OP_ABORT
  - response tags RSP_WR, RSP_RD, RSP_START, RSP_ABORT, RSP_ERR
  - parser and TX state encodings
- One sub-module, ft_tx_sched: TX FSM, pixel latch, response bytes and tx mux. The parser stays in ft_cmd_ctrl.

Test Plan:
- RX bytes 01 05 A5 -> reg_we for 1 cycle with reg_addr=05, reg_wdata=A5; TX FIFO receives 81 05.
- RX bytes 02 07 xx, reg_rdata=3C the cycle after reg_re -> TX receives 82 3C; no reg_we.
- RX bytes 7F 00 00 -> no strobes; TX receives EE 7F. RX bytes 03 00 00 -> one readout_start pulse; TX receives 83 00.
- pix_valid held with words 1234 and ABCD while a write command arrives mid-stream -> TX sequence 12 34, then 81 xx, then AB CD; no pair split.
- tx_wfull held high for 10 cycles during T_PIX1 -> tx_winc=0 and tx_wdata stable; byte written once after release; no byte lost or duplicated.
- Send 01 05 only, then idle TIMEOUT cycles (TIMEOUT=16 in bench) -> drop_cnt=1, no response. The next frame 02 05 00 parses correctly. Assert rst mid-frame -> all outputs 0 and next frame parses.
